// File: rtl/axis_noc_inject_mux_if.sv
// Bundle of the per-channel AXI-Stream sources and the router injection port
// (flit/dest/tail/send/credit plus status) of axis_noc_inject_mux.
interface axis_noc_inject_mux_if #(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned TDATA_WIDTH       = 128,
    parameter int unsigned TID_WIDTH         = 2,
    parameter int unsigned TDEST_WIDTH       = 4,
    parameter int unsigned DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4,
    parameter int unsigned CW                = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int unsigned GW                = $clog2(NUM_CHANNELS)
);
    logic [NUM_CHANNELS-1:0]             s_axis_tvalid;
    logic [NUM_CHANNELS-1:0]             s_axis_tready;
    logic [NUM_CHANNELS*TDATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_CHANNELS-1:0]             s_axis_tlast;
    logic [NUM_CHANNELS*TID_WIDTH-1:0]   s_axis_tid;
    logic [NUM_CHANNELS*TDEST_WIDTH-1:0] s_axis_tdest;

    logic [TDATA_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0]  dest_out;
    logic                   is_tail_out;
    logic                   send_out;
    logic                   credit_in;
    logic [CW-1:0]          credit_count;
    logic [GW-1:0]          grant_chan;
    logic                   credit_err;

    // Mux side: receives the AXIS sources, drives the router port.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, s_axis_tdest, credit_in,
        output s_axis_tready, data_out, dest_out, is_tail_out, send_out, credit_count,
               grant_chan, credit_err
    );

    // Source / router side.
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, s_axis_tdest, credit_in,
        input  s_axis_tready, data_out, dest_out, is_tail_out, send_out, credit_count,
               grant_chan, credit_err
    );
endinterface

// File: rtl/axis_noc_inject_mux.sv
// NoC injection front end: packet-atomic round-robin merge of N AXIS sources onto one
// router injection port, with sender-side credit flow control.
module axis_noc_inject_mux #(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned TDATA_WIDTH       = 128,
    parameter int unsigned TID_WIDTH         = 2,
    parameter int unsigned TDEST_WIDTH       = 4,
    parameter int unsigned DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4
) (
    input  logic                 clk_noc,
    input  logic                 rst_n,
    axis_noc_inject_mux_if.slave bus
);
    localparam int unsigned   CW        = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int unsigned   GW        = $clog2(NUM_CHANNELS);
    localparam logic [CW-1:0] CreditMax = CW'(FLIT_BUFFER_DEPTH);
    localparam logic [GW-1:0] RrInit    = GW'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          lock_q, lock_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic                   err_q, err_d;
    logic                   send_q, send_d;
    logic                   tail_q, tail_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;

    logic [TDATA_WIDTH-1:0] tdata_arr [NUM_CHANNELS];
    logic [TID_WIDTH-1:0]   tid_arr   [NUM_CHANNELS];
    logic [TDEST_WIDTH-1:0] tdest_arr [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_unpack
        assign tdata_arr[c] = bus.s_axis_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
        assign tid_arr[c]   = bus.s_axis_tid[c*TID_WIDTH +: TID_WIDTH];
        assign tdest_arr[c] = bus.s_axis_tdest[c*TDEST_WIDTH +: TDEST_WIDTH];
    end

    logic                    can_send;
    logic                    win_found;
    logic [GW-1:0]           win_chan;
    logic [GW-1:0]           cand;
    logic [GW-1:0]           sel_chan;
    logic [NUM_CHANNELS-1:0] ready;
    logic                    hs;

    // A credit arriving this cycle only becomes usable next cycle.
    assign can_send = (credit_q != '0);

    // Round-robin search starting just above the last packet's channel.
    always_comb begin
        win_found = 1'b0;
        win_chan  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            cand = GW'((32'(rr_q) + i) % NUM_CHANNELS);
            if (!win_found && bus.s_axis_tvalid[cand]) begin
                win_found = 1'b1;
                win_chan  = cand;
            end
        end
    end

    assign sel_chan = (state_q == StLocked) ? lock_q : win_chan;

    // Gated by rst_n so no source sees ready while reset is held.
    always_comb begin
        ready = '0;
        if (rst_n && (state_q == StLocked || win_found)) begin
            ready[sel_chan] = can_send;
        end
    end

    assign hs = ready[sel_chan] & bus.s_axis_tvalid[sel_chan];

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        err_d    = err_q;
        send_d   = 1'b0;
        tail_d   = tail_q;
        data_d   = data_q;
        dest_d   = dest_q;

        if (hs) begin
            send_d  = 1'b1;
            data_d  = tdata_arr[sel_chan];
            dest_d  = {tid_arr[sel_chan], tdest_arr[sel_chan]};
            tail_d  = bus.s_axis_tlast[sel_chan];
            grant_d = sel_chan;
            case (state_q)
                StIdle: begin
                    if (bus.s_axis_tlast[sel_chan]) begin
                        rr_d = sel_chan;
                    end else begin
                        state_d = StLocked;
                        lock_d  = sel_chan;
                    end
                end
                StLocked: begin
                    if (bus.s_axis_tlast[sel_chan]) begin
                        state_d = StIdle;
                        rr_d    = sel_chan;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Simultaneous send and credit return cancel out.
        case ({hs, bus.credit_in})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CreditMax) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lock_q   <= '0;
            rr_q     <= RrInit;
            grant_q  <= '0;
            credit_q <= CreditMax;
            err_q    <= 1'b0;
            send_q   <= 1'b0;
            tail_q   <= 1'b0;
            data_q   <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            send_q   <= send_d;
            tail_q   <= tail_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
        end
    end

    assign bus.s_axis_tready = ready;
    assign bus.data_out      = data_q;
    assign bus.dest_out      = dest_q;
    assign bus.is_tail_out   = tail_q;
    assign bus.send_out      = send_q;
    assign bus.credit_count  = credit_q;
    assign bus.grant_chan    = grant_q;
    assign bus.credit_err    = err_q;
endmodule

// File: doc/axis_noc_inject_mux.md
Name: axis_noc_inject_mux

Overview:
Multi-channel NoC injection front end. Merges NUM_CHANNELS independent user AXI-Stream sources into the single local injection port of a router (flit/dest/is_tail/send/credit interface), with packet-atomic round-robin arbitration and sender-side credit flow control. Generalises the one-source, one-flit-per-beat injection path of the current router wrap to N sources sharing one port. Sits between user logic and router input port 0, in the clk_noc domain (SERIALIZATION_FACTOR = 1, CLKCROSS_FACTOR = 1).

Parameters:
NUM_CHANNELS, 4, number of user AXIS source channels (>= 2)
TDATA_WIDTH, 128, AXIS data width; also the flit width
TID_WIDTH, 2, AXIS tid width
TDEST_WIDTH, 4, AXIS tdest width
DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, router dest field width
FLIT_BUFFER_DEPTH, 4, downstream input-buffer depth; initial and maximum credit count
CW, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived)

Ports:
clk_noc  in  1  NoC clock; the only clock in the block
rst_n  in  1  asynchronous active-low reset
s_axis_tvalid  in  NUM_CHANNELS  per-channel valid
s_axis_tready  out  NUM_CHANNELS  per-channel ready
s_axis_tdata  in  NUM_CHANNELS*TDATA_WIDTH  per-channel data; channel c at bits [c*TDATA_WIDTH +: TDATA_WIDTH]
s_axis_tlast  in  NUM_CHANNELS  per-channel end of packet
s_axis_tid  in  NUM_CHANNELS*TID_WIDTH  per-channel tid
s_axis_tdest  in  NUM_CHANNELS*TDEST_WIDTH  per-channel tdest
data_out  out  TDATA_WIDTH  flit to router
dest_out  out  DEST_WIDTH  {tid, tdest} of the flit
is_tail_out  out  1  flit is the packet tail
send_out  out  1  one-cycle flit strobe
credit_in  in  1  one-cycle pulse: one downstream buffer slot freed
credit_count  out  CW  current credits available
grant_chan  out  $clog2(NUM_CHANNELS)  channel currently holding or last holding the port
credit_err  out  1  sticky: credit received while counter already at FLIT_BUFFER_DEPTH

Behaviour:
- Reset (async assert, sync release on clk_noc): send_out=0, data_out=0, dest_out=0, is_tail_out=0, credit_count=FLIT_BUFFER_DEPTH, credit_err=0, state=IDLE, rr pointer=NUM_CHANNELS-1 (channel 0 highest priority after reset), grant_chan=0, all s_axis_tready=0.
- can_send = (credit_count != 0). A credit_in arriving in the same cycle does NOT enable a send in that cycle.
- State IDLE: winner = first channel with tvalid=1, searching upward (with wrap) from rr pointer+1. s_axis_tready[winner] = can_send, all others 0 (combinational). On handshake: if tlast=1, stay IDLE and set rr pointer=winner; else go LOCKED on winner. No valid channel: all tready=0, stay IDLE.
- State LOCKED(c): only tready[c] = can_send; all others 0 regardless of valid. Other channels never interleave flits into an open packet. On handshake with tlast=1: go IDLE, rr pointer=c. A gap in tvalid[c] holds LOCKED indefinitely.
- grant_chan updates on every accepted flit to the accepting channel.
- Output: registered, latency 1. Cycle after handshake on channel c: send_out=1, data_out=tdata[c], dest_out={tid[c], tdest[c]}, is_tail_out=tlast[c]. Otherwise send_out=0 and data/dest/tail hold their last value.
- Maximum throughput: one flit per cycle while credits last.
- Credit counter: handshake only -> -1; credit_in only -> +1; both -> unchanged. Never goes below 0 (guaranteed by can_send). credit_in with counter == FLIT_BUFFER_DEPTH and no handshake -> counter saturates, credit_err set; cleared only by reset.
- Reset mid-packet: state returns to IDLE; upstream must restart the packet. No partial-packet tail is synthesised.

Test Plan:
- Single channel 1, 3-flit packet (D0..D2, tdest=5, tid=1), credits=4 -> send_out high 3 consecutive cycles, one cycle after each handshake, dest_out=6'b01_0101, is_tail_out only on D2; credit_count 4->1.
- Channels 0 and 2 both valid with 2-flit packets from reset -> channel 0 packet fully sent first, then channel 2; no interleave; grant_chan 0 then 2.
- All 4 channels continuously offering 1-flit packets, credit_in pulsed every cycle -> grant order 0,1,2,3,0,... and send_out high every cycle.
- No credit_in, 6-flit packet on channel 1 -> exactly 4 flits sent, then tready[1]=0 with credit_count=0; one credit_in pulse -> tready high the next cycle, 5th flit accepted.
- Handshake and credit_in in the same cycle with credit_count=2 -> count stays 2; credit_in at count=4 with no send -> count stays 4, credit_err=1 and remains set.
- rst_n asserted while LOCKED on channel 3 after 2 of 4 flits -> send_out=0, credit_count=4, IDLE; after release, channel 0 valid wins over channel 3.
